// File: rtl/execute_pkg.sv
// Shared types and funct encodings for the EX stage and its iterative mul/div unit.
package execute_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_SLT, CTRL_SLTU,
        CTRL_SLL, CTRL_SRL, CTRL_SRA, CTRL_MFHI, CTRL_MFLO,
        CTRL_MULT, CTRL_MULTU, CTRL_DIV, CTRL_DIVU, CTRL_ILLEGAL
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } md_state_e;

    function automatic alu_ctrl_e decode_ctrl(input alu_op_e op, input logic [5:0] funct);
        alu_ctrl_e c;
        c = CTRL_ILLEGAL;
        case (op)
            ALU_ADD: c = CTRL_ADD;
            ALU_SUB: c = CTRL_SUB;
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD:   c = CTRL_ADD;
                    FN_SUB:   c = CTRL_SUB;
                    FN_AND:   c = CTRL_AND;
                    FN_OR:    c = CTRL_OR;
                    FN_SLT:   c = CTRL_SLT;
                    FN_SLTU:  c = CTRL_SLTU;
                    FN_SLL:   c = CTRL_SLL;
                    FN_SRL:   c = CTRL_SRL;
                    FN_SRA:   c = CTRL_SRA;
                    FN_MFHI:  c = CTRL_MFHI;
                    FN_MFLO:  c = CTRL_MFLO;
                    FN_MULT:  c = CTRL_MULT;
                    FN_MULTU: c = CTRL_MULTU;
                    FN_DIV:   c = CTRL_DIV;
                    FN_DIVU:  c = CTRL_DIVU;
                    default:  c = CTRL_ILLEGAL;
                endcase
            end
            default: c = CTRL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider on operand magnitudes,
// with sign fix-up folded into the final (commit) cycle.
//   state | meaning
//   IDLE  | waiting for start
//   MUL   | shift-add step per cycle, cnt counts XLEN-1 down to 0
//   DIV   | restoring-divide step per cycle, cnt counts XLEN-1 down to 0
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            commit_ok,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_res,
    output logic [XLEN-1:0] lo_res
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e         state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc_hi, acc_lo, mag_b;
    logic              neg_q, neg_r, div_zero;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign a_neg = is_signed && op_a[XLEN-1];
    assign b_neg = is_signed && op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;
    assign busy  = (state != IDLE);

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        rem_sh  = {acc_hi, acc_lo[XLEN-1]};
        trial   = rem_sh - {1'b0, mag_b};
        hi_step = mul_sum[XLEN:1];
        lo_step = {mul_sum[0], acc_lo[XLEN-1:1]};
        if (state == DIV) begin
            if (!trial[XLEN]) begin
                hi_step = trial[XLEN-1:0];
                lo_step = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_step = rem_sh[XLEN-1:0];
                lo_step = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // The count-0 step is never registered; it feeds the fixed-up result directly.
    always_comb begin
        prod     = {hi_step, lo_step};
        prod_fix = neg_q ? -prod : prod;
        hi_res   = prod_fix[2*XLEN-1:XLEN];
        lo_res   = prod_fix[XLEN-1:0];
        if (state == DIV) begin
            lo_res = div_zero ? '1 : (neg_q ? -lo_step : lo_step);
            hi_res = neg_r ? -hi_step : hi_step;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = is_div ? DIV : MUL;
            MUL, DIV: begin
                if (cnt == '0 && commit_ok) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                cnt      <= CNT_W'(XLEN - 1);
                acc_hi   <= '0;
                acc_lo   <= a_mag;
                mag_b    <= b_mag;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (op_b == '0);
            end else if (state != IDLE && cnt != '0) begin
                acc_hi <= hi_step;
                acc_lo <= lo_step;
                cnt    <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Handshaked EX stage: single-cycle ALU, branch target adder, HI/LO and a registered
// output beat; mult/div are delegated to muldiv_iter and block issue until they commit.
module execute_stage
    import execute_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] read_data_1,
    input  logic [XLEN-1:0] read_data_2,
    input  logic [XLEN-1:0] extended_offset,
    input  logic [XLEN-1:0] old_address,
    input  logic [1:0]      alu_op,
    input  logic            alu_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [XLEN-1:0] new_address,
    output logic            illegal
);

    logic [XLEN-1:0]    op_b, res, branch, hi_q, lo_q, md_addr, md_hi, md_lo;
    logic [5:0]         funct;
    logic [SHAMT_W-1:0] shamt;
    alu_ctrl_e          ctrl;
    logic               ill, is_md, accept, commit_ok, md_busy, md_done;

    assign funct     = extended_offset[5:0];
    assign shamt     = extended_offset[SHAMT_W+5:6];
    assign op_b      = alu_src ? extended_offset : read_data_2;
    assign ctrl      = decode_ctrl(alu_op_e'(alu_op), funct);
    assign is_md     = (ctrl == CTRL_MULT) || (ctrl == CTRL_MULTU) ||
                       (ctrl == CTRL_DIV)  || (ctrl == CTRL_DIVU);
    assign commit_ok = !out_valid || out_ready;
    assign in_ready  = !md_busy && commit_ok;
    assign accept    = in_valid && in_ready;
    assign branch    = old_address + {extended_offset[XLEN-3:0], 2'b00};

    always_comb begin
        res = '0;
        ill = 1'b0;
        case (ctrl)
            CTRL_ADD:  res = read_data_1 + op_b;
            CTRL_SUB:  res = read_data_1 - op_b;
            CTRL_AND:  res = read_data_1 & op_b;
            CTRL_OR:   res = read_data_1 | op_b;
            CTRL_SLT:  res = {{(XLEN-1){1'b0}}, $signed(read_data_1) < $signed(op_b)};
            CTRL_SLTU: res = {{(XLEN-1){1'b0}}, read_data_1 < op_b};
            CTRL_SLL:  res = op_b << shamt;
            CTRL_SRL:  res = op_b >> shamt;
            CTRL_SRA:  res = $unsigned($signed(op_b) >>> shamt);
            CTRL_MFHI: res = hi_q;
            CTRL_MFLO: res = lo_q;
            CTRL_ILLEGAL: ill = 1'b1;
            default:   res = '0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_md),
        .is_div    ((ctrl == CTRL_DIV) || (ctrl == CTRL_DIVU)),
        .is_signed ((ctrl == CTRL_MULT) || (ctrl == CTRL_DIV)),
        .op_a      (read_data_1),
        .op_b      (op_b),
        .commit_ok (commit_ok),
        .busy      (md_busy),
        .done      (md_done),
        .hi_res    (md_hi),
        .lo_res    (md_lo)
    );

    // md_done and a single-cycle accept are mutually exclusive: busy gates in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alu_result  <= '0;
            zero        <= 1'b0;
            new_address <= '0;
            illegal     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            md_addr     <= '0;
        end else begin
            if (md_done) begin
                hi_q        <= md_hi;
                lo_q        <= md_lo;
                out_valid   <= 1'b1;
                alu_result  <= '0;
                zero        <= 1'b1;
                new_address <= md_addr;
                illegal     <= 1'b0;
            end else if (accept && !is_md) begin
                out_valid   <= 1'b1;
                alu_result  <= res;
                zero        <= (res == '0);
                new_address <= branch;
                illegal     <= ill;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && is_md) md_addr <= branch;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops plus
// hand-written mult/div, back-pressure and reset-abort sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] read_data_1 = '0, read_data_2 = '0, extended_offset = '0, old_address = '0;
    logic [1:0]  alu_op = '0;
    logic        alu_src = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result, new_address;
    logic        zero, illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .extended_offset(extended_offset), .old_address(old_address),
        .alu_op(alu_op), .alu_src(alu_src), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .zero(zero),
        .new_address(new_address), .illegal(illegal)
    );

    typedef struct {
        logic [1:0]  op;
        logic        src;
        logic [31:0] a, b, ext, old;
        logic [31:0] res;
        logic        zr;
        logic [31:0] addr;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ext, input logic [31:0] old);
        int t;
        alu_op = op; alu_src = src; read_data_1 = a; read_data_2 = b;
        extended_offset = ext; old_address = old; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t == 100) chk("issue_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic md_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b);
        int lat;
        issue(2'b10, 1'b0, a, b, {26'd0, fn}, 32'h0000_0100);
        chk({name, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd32);
        chk({name, "_result"}, alu_result, 32'd0);
        chk({name, "_zero"}, {31'd0, zero}, 32'd1);
        chk({name, "_addr"}, new_address, 32'h0000_0100 + {26'd0, fn, 2'b00});
    endtask

    task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        issue(2'b10, 1'b0, 32'd0, 32'd0, 32'h10, 32'd0);
        chk({name, "_mfhi"}, alu_result, hi);
        issue(2'b10, 1'b0, 32'd0, 32'd0, 32'h12, 32'd0);
        chk({name, "_mflo"}, alu_result, lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         op     src   a             b             ext           old           res           z     addr          ill
        vecs[0]  = '{2'b00, 1'b1, 32'd5,        32'd0,        32'hFFFFFFF9, 32'h1000,     32'hFFFFFFFE, 1'b0, 32'h0FE4,     1'b0};
        vecs[1]  = '{2'b01, 1'b0, 32'h1234,     32'h1234,     32'd0,        32'h2000,     32'd0,        1'b1, 32'h2000,     1'b0};
        vecs[2]  = '{2'b00, 1'b0, 32'd10,       32'd20,       32'h20,       32'd0,        32'd30,       1'b0, 32'h80,       1'b0};
        vecs[3]  = '{2'b10, 1'b0, 32'h7FFFFFFF, 32'd1,        32'h20,       32'd0,        32'h80000000, 1'b0, 32'h80,       1'b0};
        vecs[4]  = '{2'b10, 1'b0, 32'd3,        32'd5,        32'h22,       32'd0,        32'hFFFFFFFE, 1'b0, 32'h88,       1'b0};
        vecs[5]  = '{2'b10, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h24,       32'd0,        32'hF000F000, 1'b0, 32'h90,       1'b0};
        vecs[6]  = '{2'b10, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h25,       32'd0,        32'hFFF0FFF0, 1'b0, 32'h94,       1'b0};
        vecs[7]  = '{2'b10, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h2A,       32'd0,        32'd1,        1'b0, 32'hA8,       1'b0};
        vecs[8]  = '{2'b10, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h2B,       32'd0,        32'd0,        1'b1, 32'hAC,       1'b0};
        vecs[9]  = '{2'b10, 1'b0, 32'd0,        32'h80000001, 32'h100,      32'd0,        32'h10,       1'b0, 32'h400,      1'b0};
        vecs[10] = '{2'b10, 1'b0, 32'd0,        32'h80000010, 32'h102,      32'd0,        32'h08000001, 1'b0, 32'h408,      1'b0};
        vecs[11] = '{2'b10, 1'b0, 32'd0,        32'h80000010, 32'h103,      32'd0,        32'hF8000001, 1'b0, 32'h40C,      1'b0};
        vecs[12] = '{2'b11, 1'b0, 32'd1,        32'd2,        32'd0,        32'd0,        32'd0,        1'b1, 32'd0,        1'b1};
        vecs[13] = '{2'b10, 1'b0, 32'd1,        32'd2,        32'h3F,       32'd0,        32'd0,        1'b1, 32'hFC,       1'b1};
        vecs[14] = '{2'b01, 1'b1, 32'h10,       32'd99,       32'h10,       32'h4,        32'd0,        1'b1, 32'h44,       1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_addr", new_address, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);

        // back-to-back issue, one op per cycle
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].ext, vecs[i].old);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), alu_result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zr});
            chk($sformatf("vec%0d_addr", i), new_address, vecs[i].addr);
            chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
        end
        @(posedge clk); #1;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // back-pressure: held beat stays put, pending op waits, then drain+accept together
        out_ready = 1'b0;
        issue(2'b01, 1'b0, 32'h1234, 32'h1234, 32'd0, 32'h2000);
        alu_op = 2'b00; alu_src = 1'b0; read_data_1 = 32'd1; read_data_2 = 32'd1;
        extended_offset = 32'd1; old_address = 32'd0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", alu_result, 32'd0);
            chk("stall_zero", {31'd0, zero}, 32'd1);
            chk("stall_addr", new_address, 32'h2000);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd1);
        chk("release_result", alu_result, 32'd2);
        chk("release_zero", {31'd0, zero}, 32'd0);
        chk("release_addr", new_address, 32'd4);

        md_op("mult", 6'b011000, 32'hFFFFFFFD, 32'd7);
        read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
        md_op("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2);
        read_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_op("divu_zero", 6'b011011, 32'd9, 32'd0);
        read_hilo("divu_zero", 32'd9, 32'hFFFFFFFF);
        md_op("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF);
        read_hilo("div_ovf", 32'd0, 32'h80000000);
        md_op("divu", 6'b011011, 32'd100, 32'd7);
        read_hilo("divu", 32'd2, 32'd14);
        md_op("multu", 6'b011001, 32'hFFFFFFFF, 32'd2);
        read_hilo("multu", 32'd1, 32'hFFFFFFFE);

        // reset partway through a divide aborts it and clears HI/LO
        issue(2'b10, 1'b0, 32'd100, 32'd7, 32'h1A, 32'd0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("middiv_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        read_hilo("abort", 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
